// File: rtl/alu_seq_ctrl_if.sv
// rtl/alu_seq_ctrl_if.sv - request/response handshake bundle for the ALU sequencing controller
interface alu_seq_ctrl_if;
  logic        req_valid;
  logic        req_ready;
  logic [4:0]  req_opcode;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_hi;
  logic [31:0] rsp_lo;
  logic        rsp_dbz;
  logic        rsp_illegal;

  // Requester / response consumer side
  modport master (
    output req_valid, req_opcode, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_hi, rsp_lo, rsp_dbz, rsp_illegal
  );

  // Controller side
  modport slave (
    input  req_valid, req_opcode, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_hi, rsp_lo, rsp_dbz, rsp_illegal
  );
endinterface

// File: rtl/alu_seq_ctrl.sv
// rtl/alu_seq_ctrl.sv - sequencing controller: ALU dispatch plus iterative signed mul/div
module alu_seq_ctrl (
  input  logic                clk,
  input  logic                clr,
  alu_seq_ctrl_if.slave       bus,
  output logic [4:0]          alu_opcode,
  output logic [31:0]         alu_a,
  output logic [31:0]         alu_b,
  input  logic [63:0]         alu_c,
  output logic                busy
);

  localparam logic [4:0] OP_MUL = 5'd3;
  localparam logic [4:0] OP_DIV = 5'd4;

  typedef enum logic [2:0] {
    IDLE, ISSUE, CAPTURE, ITER, FIX, RESP
  } state_t;

  state_t      state_q, state_d;
  logic [4:0]  op_q, op_d;
  // Single-cycle ops: opnd holds A and acc[31:0] holds B.
  // Mul: opnd = |A| (multiplicand), acc = {partial product, multiplier}.
  // Div: opnd = |B| (divisor), acc = {remainder, dividend/quotient}.
  logic [31:0] opnd_q, opnd_d;
  logic [63:0] acc_q, acc_d;
  logic [5:0]  cnt_q, cnt_d;
  logic        sign_q, sign_d;     // product / quotient sign
  logic        rsign_q, rsign_d;   // remainder sign (follows dividend)
  logic [31:0] rsp_hi_q, rsp_hi_d;
  logic [31:0] rsp_lo_q, rsp_lo_d;
  logic        dbz_q, dbz_d;
  logic        ill_q, ill_d;

  logic [31:0] abs_a, abs_b;
  logic [32:0] mul_sum;
  logic [63:0] mul_next;
  logic [32:0] div_rem;
  logic        div_ge;
  logic [31:0] div_sub;
  logic [63:0] div_next;
  logic [63:0] mul_fix;
  logic [31:0] quo_fix, rem_fix;

  assign abs_a = bus.req_a[31] ? (~bus.req_a + 32'd1) : bus.req_a;
  assign abs_b = bus.req_b[31] ? (~bus.req_b + 32'd1) : bus.req_b;

  // Shift-add step: add multiplicand into the upper half when the multiplier LSB is set, then shift right.
  assign mul_sum  = {1'b0, acc_q[63:32]} + {1'b0, opnd_q};
  assign mul_next = acc_q[0] ? {mul_sum, acc_q[31:1]} : {1'b0, acc_q[63:1]};

  // Restoring step: shift the next dividend bit into the remainder and subtract when it fits.
  assign div_rem  = {acc_q[63:32], acc_q[31]};
  assign div_ge   = (div_rem >= {1'b0, opnd_q});
  assign div_sub  = div_rem[31:0] - opnd_q;
  assign div_next = {(div_ge ? div_sub : div_rem[31:0]), acc_q[30:0], div_ge};

  assign mul_fix = sign_q  ? (~acc_q + 64'd1) : acc_q;
  assign quo_fix = sign_q  ? (~acc_q[31:0] + 32'd1) : acc_q[31:0];
  assign rem_fix = rsign_q ? (~acc_q[63:32] + 32'd1) : acc_q[63:32];

  assign bus.req_ready   = (state_q == IDLE);
  assign bus.rsp_valid   = (state_q == RESP);
  assign bus.rsp_hi      = rsp_hi_q;
  assign bus.rsp_lo      = rsp_lo_q;
  assign bus.rsp_dbz     = dbz_q;
  assign bus.rsp_illegal = ill_q;
  assign busy            = (state_q != IDLE);

  // ALU inputs are non-zero only during ISSUE so the ALU otherwise reloads 0.
  assign alu_opcode = (state_q == ISSUE) ? op_q : 5'd0;
  assign alu_a      = (state_q == ISSUE) ? opnd_q : 32'd0;
  assign alu_b      = (state_q == ISSUE) ? acc_q[31:0] : 32'd0;

  // Next-state and datapath updates for the operation sequencer
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    opnd_d   = opnd_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    sign_d   = sign_q;
    rsign_d  = rsign_q;
    rsp_hi_d = rsp_hi_q;
    rsp_lo_d = rsp_lo_q;
    dbz_d    = dbz_q;
    ill_d    = ill_q;

    case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          op_d   = bus.req_opcode;
          cnt_d  = 6'd0;
          dbz_d  = 1'b0;
          ill_d  = 1'b0;
          if (bus.req_opcode == OP_MUL) begin
            opnd_d  = abs_a;
            acc_d   = {32'd0, abs_b};
            sign_d  = bus.req_a[31] ^ bus.req_b[31];
            state_d = ITER;
          end else if (bus.req_opcode == OP_DIV) begin
            if (bus.req_b == 32'd0) begin
              rsp_hi_d = bus.req_a;
              rsp_lo_d = 32'hFFFF_FFFF;
              dbz_d    = 1'b1;
              state_d  = RESP;
            end else begin
              opnd_d  = abs_b;
              acc_d   = {32'd0, abs_a};
              sign_d  = bus.req_a[31] ^ bus.req_b[31];
              rsign_d = bus.req_a[31];
              state_d = ITER;
            end
          end else if (bus.req_opcode != 5'd0 && bus.req_opcode < 5'd16) begin
            opnd_d  = bus.req_a;
            acc_d   = {32'd0, bus.req_b};
            state_d = ISSUE;
          end else begin
            rsp_hi_d = 32'd0;
            rsp_lo_d = 32'd0;
            ill_d    = 1'b1;
            state_d  = RESP;
          end
        end
      end
      ISSUE: begin
        state_d = CAPTURE;
      end
      CAPTURE: begin
        rsp_hi_d = alu_c[63:32];
        rsp_lo_d = alu_c[31:0];
        state_d  = RESP;
      end
      ITER: begin
        acc_d = (op_q == OP_MUL) ? mul_next : div_next;
        if (cnt_q == 6'd31) begin
          cnt_d   = 6'd0;
          state_d = FIX;
        end else begin
          cnt_d = cnt_q + 6'd1;
        end
      end
      FIX: begin
        if (op_q == OP_MUL) begin
          rsp_hi_d = mul_fix[63:32];
          rsp_lo_d = mul_fix[31:0];
        end else begin
          rsp_hi_d = rem_fix;
          rsp_lo_d = quo_fix;
        end
        state_d = RESP;
      end
      RESP: begin
        if (bus.rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; clr overrides every transition
  always_ff @(posedge clk) begin
    if (clr) begin
      state_q  <= IDLE;
      op_q     <= 5'd0;
      opnd_q   <= 32'd0;
      acc_q    <= 64'd0;
      cnt_q    <= 6'd0;
      sign_q   <= 1'b0;
      rsign_q  <= 1'b0;
      rsp_hi_q <= 32'd0;
      rsp_lo_q <= 32'd0;
      dbz_q    <= 1'b0;
      ill_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      opnd_q   <= opnd_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      sign_q   <= sign_d;
      rsign_q  <= rsign_d;
      rsp_hi_q <= rsp_hi_d;
      rsp_lo_q <= rsp_lo_d;
      dbz_q    <= dbz_d;
      ill_q    <= ill_d;
    end
  end

endmodule
